// File: rtl/imem_loader_if.sv
// Byte stream and imem write-port bundle for the instruction-memory loader.
// The master side is the host/byte source. The slave side is the loader.
interface imem_loader_if;
  logic       s_valid_i;
  logic [7:0] s_data_i;
  logic       s_ready_o;
  logic       wen_o;
  logic [63:0] waddr_o;
  logic [7:0] wdata_o;

  modport master (
    output s_valid_i, s_data_i,
    input  s_ready_o, wen_o, waddr_o, wdata_o
  );

  modport slave (
    input  s_valid_i, s_data_i,
    output s_ready_o, wen_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader.
// It takes a byte stream over valid/ready and writes one byte per cycle at base+offset.
// It keeps a 16-bit running checksum of the accepted bytes.
// It holds the core until the image is complete, then presents the entry PC.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [63:0]         base_addr_i,
  input  logic [15:0]         len_i,
  input  logic [63:0]         entry_pc_i,
  imem_loader_if.slave        bus,
  output logic                core_hold_o,
  output logic [63:0]         entry_pc_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic [15:0]         checksum_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0]  TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [64:0] MEM_LIMIT  = 65'(MEM_BYTES);

  logic [1:0]  state;
  logic [63:0] base_q;
  logic [15:0] offset_q;
  logic [15:0] remaining_q;
  logic [7:0]  timer_q;
  logic        wen_q;
  logic [63:0] waddr_q;
  logic [7:0]  wdata_q;
  logic [63:0] entry_q;
  logic [15:0] sum_q;
  logic [1:0]  code_q;

  logic        ready;
  logic        accept;
  logic [64:0] last_addr;
  logic        range_bad;

  // Handshake and the 65-bit start-time range check. The extra top bit means base+len-1 never wraps.
  always_comb begin
    ready     = (state == ST_LOAD);
    accept    = ready & bus.s_valid_i;
    last_addr = {1'b0, base_addr_i} + {49'b0, len_i} - 65'd1;
    range_bad = (len_i != 16'd0) && (last_addr >= MEM_LIMIT);
  end

  // Load sequencing. An accepted byte is written on the following cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      base_q      <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
      timer_q     <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      entry_q     <= '0;
      sum_q       <= '0;
      code_q      <= ERR_NONE;
    end else begin
      wen_q <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            wen_q       <= 1'b1;
            waddr_q     <= base_q + {48'b0, offset_q};
            wdata_q     <= bus.s_data_i;
            offset_q    <= offset_q + 16'd1;
            remaining_q <= remaining_q - 16'd1;
            sum_q       <= sum_q + {8'b0, bus.s_data_i};
            timer_q     <= '0;
            if (remaining_q == 16'd1) begin
              state <= ST_DONE;
            end
          end else begin
            timer_q <= timer_q + 8'd1;
            if (timer_q == TIMER_LAST) begin
              state  <= ST_ERR;
              code_q <= ERR_TIMEOUT;
            end
          end
        end
        default: begin
          if (start_i) begin
            base_q      <= base_addr_i;
            entry_q     <= entry_pc_i;
            remaining_q <= len_i;
            offset_q    <= '0;
            sum_q       <= '0;
            timer_q     <= '0;
            code_q      <= ERR_NONE;
            if (len_i == 16'd0) begin
              state <= ST_DONE;
            end else if (range_bad) begin
              state  <= ST_ERR;
              code_q <= ERR_RANGE;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
      endcase
    end
  end

  // The core is released only in DONE and only once the final write pulse has gone.
  always_comb begin
    core_hold_o = !((state == ST_DONE) && !wen_q);
  end

  assign bus.s_ready_o = ready;
  assign bus.wen_o     = wen_q;
  assign bus.waddr_o   = waddr_q;
  assign bus.wdata_o   = wdata_q;
  assign entry_pc_o    = entry_q;
  assign done_o        = (state == ST_DONE);
  assign err_o         = (state == ST_ERR);
  assign err_code_o    = code_q;
  assign checksum_o    = sum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader.
// Each accepted byte pushes its expected write onto a queue.
// A monitor pops the queue on every wen pulse and compares the write.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] base = '0;
  logic [15:0] len = '0;
  logic [63:0] entry = '0;
  logic        hold;
  logic [63:0] entry_pc;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] checksum;

  imem_loader_if bus();

  imem_loader #(.MEM_BYTES(1024), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .len_i(len),
    .entry_pc_i(entry), .bus(bus.slave), .core_hold_o(hold), .entry_pc_o(entry_pc),
    .done_o(done), .err_o(err), .err_code_o(err_code), .checksum_o(checksum)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned wr_count = 0;
  logic [63:0] m_base;
  int unsigned m_sent;
  logic [15:0] m_sum;
  logic [71:0] exp_q[$];
  logic [7:0]  t1 [10] = '{8'h30, 8'hF1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_ready"}, 64'(bus.s_ready_o), 64'd0);
    check({pfx, "_wen"}, 64'(bus.wen_o), 64'd0);
    check({pfx, "_waddr"}, bus.waddr_o, 64'd0);
    check({pfx, "_wdata"}, 64'(bus.wdata_o), 64'd0);
    check({pfx, "_hold"}, 64'(hold), 64'd1);
    check({pfx, "_entry"}, entry_pc, 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
    check({pfx, "_err"}, 64'(err), 64'd0);
    check({pfx, "_code"}, 64'(err_code), 64'd0);
    check({pfx, "_sum"}, 64'(checksum), 64'd0);
  endtask

  // Called at a negedge. It returns one negedge later, with the start pulse seen by the DUT.
  task automatic do_start(input logic [63:0] b, input logic [15:0] l, input logic [63:0] e);
    start = 1'b1; base = b; len = l; entry = e;
    m_base = b; m_sent = 0; m_sum = '0; wr_count = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge. It offers one byte after `idle` empty cycles and returns one negedge later.
  task automatic send_byte(input logic [7:0] d, input int unsigned idle);
    repeat (idle) @(negedge clk);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = d;
    if (bus.s_ready_o) begin
      exp_q.push_back({m_base + 64'(m_sent), d});
      m_sent++;
      m_sum += {8'b0, d};
    end
    @(negedge clk);
    bus.s_valid_i = 1'b0;
  endtask

  // Scoreboard side: every write pulse must match the oldest accepted byte.
  always @(negedge clk) begin
    if (!rst && bus.wen_o) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("spurious_wen", 64'd1, 64'd0);
      end else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        check("waddr", bus.waddr_o, e[71:8]);
        check("wdata", 64'(bus.wdata_o), 64'(e[7:0]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    @(negedge clk); @(negedge clk);
    check_reset_values("rst0");
    rst = 1'b0;
    @(negedge clk);

    // T1: contiguous stream of 10 bytes
    do_start(64'd0, 16'd10, 64'd0);
    for (int i = 0; i < 10; i++) send_byte(t1[i], 0);
    check("t1_wen_last", 64'(bus.wen_o), 64'd1);
    check("t1_hold_during_wen", 64'(hold), 64'd1);
    @(negedge clk); #1;
    check("t1_hold_fall", 64'(hold), 64'd0);
    check("t1_done", 64'(done), 64'd1);
    check("t1_writes", 64'(wr_count), 64'd10);
    check("t1_sum", 64'(checksum), 64'h0122);
    check("t1_model_sum", 64'(checksum), 64'(m_sum));
    check("t1_entry", entry_pc, 64'd0);

    // T2: reload from DONE with valid toggling between bytes
    do_start(64'd0, 16'd10, 64'd0);
    check("t2_hold_rise", 64'(hold), 64'd1);
    check("t2_not_done", 64'(done), 64'd0);
    for (int i = 0; i < 10; i++) send_byte(t1[i], (i > 0) ? 1 : 0);
    @(negedge clk); #1;
    check("t2_done", 64'(done), 64'd1);
    check("t2_err", 64'(err), 64'd0);
    check("t2_writes", 64'(wr_count), 64'd10);
    check("t2_sum", 64'(checksum), 64'h0122);
    check("t2_hold", 64'(hold), 64'd0);

    // T3a: a load that ends exactly on the last valid address is legal
    do_start(64'd1019, 16'd5, 64'd8);
    check("t3a_ready", 64'(bus.s_ready_o), 64'd1);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 0);
    @(negedge clk); #1;
    check("t3a_done", 64'(done), 64'd1);
    check("t3a_writes", 64'(wr_count), 64'd5);
    check("t3a_sum", 64'(checksum), 64'd15);
    check("t3a_entry", entry_pc, 64'd8);

    // T3b: a load that runs one byte past the end is rejected at start
    do_start(64'd1020, 16'd5, 64'd0);
    #1;
    check("t3b_err", 64'(err), 64'd1);
    check("t3b_code", 64'(err_code), 64'd1);
    check("t3b_hold", 64'(hold), 64'd1);
    check("t3b_ready", 64'(bus.s_ready_o), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("t3b_writes", 64'(wr_count), 64'd0);

    // T4: timeout after 2 of 4 bytes
    do_start(64'd100, 16'd4, 64'd0);
    send_byte(8'hA5, 0);
    send_byte(8'h7E, 0);
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t4_err_seen", 64'(err), 64'd1);
    check("t4_idle_cycles", 64'(n), 64'd255);
    check("t4_code", 64'(err_code), 64'd2);
    check("t4_sum", 64'(checksum), 64'h0123);
    check("t4_hold", 64'(hold), 64'd1);
    check("t4_done", 64'(done), 64'd0);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 8'hEE;
    check("t4_ready_in_err", 64'(bus.s_ready_o), 64'd0);
    @(negedge clk);
    bus.s_valid_i = 1'b0;
    @(negedge clk); #1;
    check("t4_writes", 64'(wr_count), 64'd2);

    // T5: zero-length load completes immediately
    do_start(64'd0, 16'd0, 64'h100);
    #1;
    check("t5_done", 64'(done), 64'd1);
    check("t5_entry", entry_pc, 64'h100);
    check("t5_hold", 64'(hold), 64'd0);
    check("t5_code", 64'(err_code), 64'd0);
    check("t5_sum", 64'(checksum), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    check("t5_writes", 64'(wr_count), 64'd0);

    // T6: reset mid-load, then a normal load with an ignored start in the middle
    do_start(64'd200, 16'd8, 64'h55);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("t6_rst");
    check("t6_writes_before_rst", 64'(wr_count), 64'd3);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(64'd300, 16'd3, 64'h40);
    send_byte(8'h10, 0);
    start = 1'b1; len = 16'd0; base = 64'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("t6_start_ignored_done", 64'(done), 64'd0);
    check("t6_start_ignored_ready", 64'(bus.s_ready_o), 64'd1);
    send_byte(8'h20, 0);
    send_byte(8'h30, 0);
    @(negedge clk); #1;
    check("t6_done", 64'(done), 64'd1);
    check("t6_sum", 64'(checksum), 64'h0060);
    check("t6_entry", entry_pc, 64'h40);
    check("t6_hold", 64'(hold), 64'd0);
    check("t6_writes", 64'(wr_count), 64'd3);

    repeat (2) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
